mix_array_sl: RTL and testbench

- Key-mixing stage of the RC5-style key schedule; runs after S-array initialisation and L-array key load.
- Reads the initialised S array and the key word array L, and writes both back in place using RC5 mixing.
- Iterates 3*max(t,c) times.
- Consumes the S RAM through an address/data interface with combinational read and synchronous write.

---
 rtl/mix_array_sl_if.sv | 29 ++
 rtl/mix_array_sl.sv | 129 ++++++++++++
 tb/tb_mix_array_sl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mix_array_sl_if.sv
// Bus bundle between the RC5 key-mixing engine and its S/L word RAMs.
// Carries the start/busy/done handshake alongside both address/data ports.
interface mix_array_sl_if #(
    parameter int w        = 32,
    parameter int t_length = 5,
    parameter int c_length = 2
);
    logic                start;
    logic                busy;
    logic                done;
    logic [w-1:0]        S_rd_data;
    logic [w-1:0]        S_wr_data;
    logic [t_length-1:0] S_address;
    logic                S_we;
    logic [w-1:0]        L_rd_data;
    logic [w-1:0]        L_wr_data;
    logic [c_length-1:0] L_address;
    logic                L_we;

    modport master (
        input  start, S_rd_data, L_rd_data,
        output busy, done, S_address, S_wr_data, S_we, L_address, L_wr_data, L_we
    );

    modport slave (
        output start, S_rd_data, L_rd_data,
        input  busy, done, S_address, S_wr_data, S_we, L_address, L_wr_data, L_we
    );
endinterface

// File: rtl/mix_array_sl.sv
// RC5 key-schedule mixing stage: folds the key words L into the expanded
// table S in place, alternating one S write and one L write per iteration.
module mix_array_sl #(
    parameter int w        = 32,
    parameter int t        = 26,
    parameter int c        = 4,
    parameter int t_length = $clog2(t),
    parameter int c_length = ($clog2(c) < 1) ? 1 : $clog2(c)
) (
    input  logic           clk2,
    input  logic           rst,
    mix_array_sl_if.master bus
);
    localparam int n_iter = 3 * ((t > c) ? t : c);
    localparam int k_w    = $clog2(n_iter + 1);
    localparam int rot_w  = $clog2(w);

    localparam logic [t_length-1:0] last_i = t_length'(t - 1);
    localparam logic [c_length-1:0] last_j = c_length'(c - 1);
    localparam logic [k_w-1:0]      last_k = k_w'(n_iter - 1);
    localparam logic [rot_w-1:0]    s_rot  = rot_w'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MIX_S = 2'd1,
        MIX_L = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [w-1:0]        a_r, a_s;
    logic [w-1:0]        b_r, b_s;
    logic [t_length-1:0] i_r, i_s;
    logic [c_length-1:0] j_r, j_s;
    logic [k_w-1:0]      k_r, k_s;
    logic [w-1:0]        ab_s;
    logic [w-1:0]        s_mix_s;
    logic [w-1:0]        l_mix_s;

    // Rotate left; the doubled word makes a zero amount a plain pass-through.
    function automatic logic [w-1:0] rotl(input logic [w-1:0] x, input logic [rot_w-1:0] r);
        logic [2*w-1:0] d;
        d = {x, x} << r;
        return d[2*w-1:w];
    endfunction

    assign ab_s    = a_r + b_r;
    assign s_mix_s = rotl(bus.S_rd_data + ab_s, s_rot);
    assign l_mix_s = rotl(bus.L_rd_data + ab_s, ab_s[rot_w-1:0]);

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            a_r     <= {w{1'b0}};
            b_r     <= {w{1'b0}};
            i_r     <= {t_length{1'b0}};
            j_r     <= {c_length{1'b0}};
            k_r     <= {k_w{1'b0}};
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            i_r     <= i_s;
            j_r     <= j_s;
            k_r     <= k_s;
        end
    end

    // Next-state and datapath update; A moves in MIX_S, B and indices in MIX_L.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        i_s     = i_r;
        j_s     = j_r;
        k_s     = k_r;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_s = MIX_S;
                    a_s     = {w{1'b0}};
                    b_s     = {w{1'b0}};
                    i_s     = {t_length{1'b0}};
                    j_s     = {c_length{1'b0}};
                    k_s     = {k_w{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            MIX_S: begin
                a_s     = s_mix_s;
                state_s = MIX_L;
            end
            MIX_L: begin
                b_s = l_mix_s;
                k_s = k_r + k_w'(1);
                if (i_r == last_i) begin
                    i_s = {t_length{1'b0}};
                end else begin
                    i_s = i_r + t_length'(1);
                end
                if (j_r == last_j) begin
                    j_s = {c_length{1'b0}};
                end else begin
                    j_s = j_r + c_length'(1);
                end
                if (k_r == last_k) begin
                    state_s = DONE;
                end else begin
                    state_s = MIX_S;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register so reset drops them at once.
    assign bus.S_address = i_r;
    assign bus.S_wr_data = s_mix_s;
    assign bus.S_we      = (state_r == MIX_S);
    assign bus.L_address = j_r;
    assign bus.L_wr_data = l_mix_s;
    assign bus.L_we      = (state_r == MIX_L);
    assign bus.busy      = (state_r == MIX_S) || (state_r == MIX_L);
    assign bus.done      = (state_r == DONE);
endmodule

// File: tb/tb_mix_array_sl.sv
// Directed bench for mix_array_sl: RAM models, a reference RC5 mixing model
// feeding a write scoreboard, and final-array comparisons.
module tb_mix_array_sl;
    logic clk2 = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk2 = ~clk2;

    mix_array_sl_if #(.w(32), .t_length(5), .c_length(2)) ia ();
    mix_array_sl_if #(.w(32), .t_length(3), .c_length(2)) ib ();

    mix_array_sl #(.w(32), .t(26), .c(4)) dut_a (.clk2(clk2), .rst(rst), .bus(ia));
    mix_array_sl #(.w(32), .t(5),  .c(3)) dut_b (.clk2(clk2), .rst(rst), .bus(ib));

    logic [31:0] sa [26];
    logic [31:0] la [4];
    logic [31:0] sb [5];
    logic [31:0] lb [3];

    assign ia.S_rd_data = sa[ia.S_address];
    assign ia.L_rd_data = la[ia.L_address];
    assign ib.S_rd_data = sb[ib.S_address];
    assign ib.L_rd_data = lb[ib.L_address];

    always @(posedge clk2) begin
        if (ia.S_we) sa[ia.S_address] <= ia.S_wr_data;
        if (ia.L_we) la[ia.L_address] <= ia.L_wr_data;
        if (ib.S_we) sb[ib.S_address] <= ib.S_wr_data;
        if (ib.L_we) lb[ib.L_address] <= ib.L_wr_data;
    end

    typedef struct packed {
        logic        is_l;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         q_a [$];
    wr_t         q_b [$];
    logic [31:0] fin_s [26];
    logic [31:0] fin_l [4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int r);
        int rr;
        rr = r & 31;
        if (rr == 0) return x;
        return (x << rr) | (x >> (32 - rr));
    endfunction

    // Reference RC5 key mixing over a snapshot of the RAMs.
    task automatic push_model(input int inst);
        logic [31:0] ms [26];
        logic [31:0] ml [4];
        logic [31:0] a = 32'd0;
        logic [31:0] b = 32'd0;
        int tt = (inst == 0) ? 26 : 5;
        int cc = (inst == 0) ? 4 : 3;
        int ii = 0;
        int jj = 0;
        int n;
        wr_t e;
        for (int x = 0; x < tt; x++) ms[x] = (inst == 0) ? sa[x] : sb[x % 5];
        for (int x = 0; x < cc; x++) ml[x] = (inst == 0) ? la[x] : lb[x % 3];
        n = 3 * ((tt > cc) ? tt : cc);
        for (int k = 0; k < n; k++) begin
            ms[ii] = rotl32(ms[ii] + a + b, 3);
            a = ms[ii];
            e = {1'b0, 8'(ii), a};
            if (inst == 0) q_a.push_back(e); else q_b.push_back(e);
            ml[jj] = rotl32(ml[jj] + a + b, int'(a + b));
            b = ml[jj];
            e = {1'b1, 8'(jj), b};
            if (inst == 0) q_a.push_back(e); else q_b.push_back(e);
            ii = (ii + 1) % tt;
            jj = (jj + 1) % cc;
        end
        for (int x = 0; x < tt; x++) fin_s[x] = ms[x];
        for (int x = 0; x < cc; x++) fin_l[x] = ml[x];
    endtask

    task automatic check_write(input int inst, input logic s_we, input logic l_we,
                               input logic [7:0] s_addr, input logic [7:0] l_addr,
                               input logic [31:0] s_d, input logic [31:0] l_d);
        wr_t got;
        wr_t e;
        int  tt = (inst == 0) ? 26 : 5;
        int  cc = (inst == 0) ? 4 : 3;
        if (s_we || l_we) begin
            chk("we_exclusive", 64'(s_we & l_we), 64'd0);
            chk("addr_range", 64'(s_we ? (int'(s_addr) < tt) : (int'(l_addr) < cc)), 64'd1);
            got = s_we ? {1'b0, s_addr, s_d} : {1'b1, l_addr, l_d};
            e = '1;
            if (inst == 0 && q_a.size() > 0) e = q_a.pop_front();
            if (inst == 1 && q_b.size() > 0) e = q_b.pop_front();
            chk("write_seq", 64'(got), 64'(e));
        end
    endtask

    always @(negedge clk2) begin
        if (rst === 1'b0) begin
            check_write(0, ia.S_we, ia.L_we, 8'(ia.S_address), 8'(ia.L_address), ia.S_wr_data, ia.L_wr_data);
            check_write(1, ib.S_we, ib.L_we, 8'(ib.S_address), 8'(ib.L_address), ib.S_wr_data, ib.L_wr_data);
        end
    end

    task automatic set_start(input int inst, input logic v);
        if (inst == 0) ia.start = v; else ib.start = v;
    endtask

    task automatic init_mem(input bit use_key);
        for (int x = 0; x < 26; x++) sa[x] <= 32'hB7E15163 + 32'(x) * 32'h9E3779B9;
        for (int x = 0; x < 5; x++)  sb[x] <= 32'hB7E15163 + 32'(x) * 32'h9E3779B9;
        for (int x = 0; x < 4; x++)
            la[x] <= use_key ? {8'(4*x+3), 8'(4*x+2), 8'(4*x+1), 8'(4*x)} : 32'd0;
        for (int x = 0; x < 3; x++) lb[x] <= 32'd0;
    endtask

    // Starts a run (called at a negedge), optionally pulses start mid-run, waits for done.
    task automatic run(input int inst, input int pulse_at, input bit first_checks);
        int   bc  = 0;
        bit   fin = 1'b0;
        logic bz;
        logic dn  = 1'b0;
        int   tt  = (inst == 0) ? 26 : 5;
        int   cc  = (inst == 0) ? 4 : 3;
        push_model(inst);
        set_start(inst, 1'b1);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk2);
            bz = (inst == 0) ? ia.busy : ib.busy;
            dn = (inst == 0) ? ia.done : ib.done;
            if (cyc == 0) begin
                chk("start_busy", 64'(bz), 64'd1);
                chk("start_done", 64'(dn), 64'd0);
            end
            if (dn) begin
                fin = 1'b1;
            end else begin
                if (bz) bc++;
                if (first_checks && bc == 1) begin
                    chk("first_s_addr", 64'(ia.S_address), 64'd0);
                    chk("first_s_wr", 64'(ia.S_wr_data), 64'hBF0A8B1D);
                end
                if (first_checks && bc == 2) chk("first_l_wr", 64'(ia.L_wr_data), 64'hB7E15163);
                set_start(inst, bc == pulse_at);
            end
        end
        set_start(inst, 1'b0);
        chk("busy_cycles", 64'(bc), (inst == 0) ? 64'd156 : 64'd30);
        chk("done_flag", 64'(dn), 64'd1);
        chk("sb_drained", 64'((inst == 0) ? q_a.size() : q_b.size()), 64'd0);
        for (int x = 0; x < tt; x++) chk("final_s", 64'((inst == 0) ? sa[x] : sb[x % 5]), 64'(fin_s[x]));
        for (int x = 0; x < cc; x++) chk("final_l", 64'((inst == 0) ? la[x] : lb[x % 3]), 64'(fin_l[x]));
    endtask

    initial begin
        int bc;
        rst = 1'b1;
        ia.start = 1'b0;
        ib.start = 1'b0;
        init_mem(1'b0);
        #2;
        chk("rst_busy", 64'(ia.busy), 64'd0);
        chk("rst_done", 64'(ia.done), 64'd0);
        chk("rst_s_we", 64'(ia.S_we), 64'd0);
        chk("rst_l_we", 64'(ia.L_we), 64'd0);
        chk("rst_s_addr", 64'(ia.S_address), 64'd0);
        chk("rst_l_addr", 64'(ia.L_address), 64'd0);
        @(negedge clk2);
        rst = 1'b0;
        @(negedge clk2);

        // zero key, first-transaction values
        run(0, -1, 1'b1);

        // key 0x00..0x0F, restarted from DONE, with an ignored start mid-run
        init_mem(1'b1);
        @(negedge clk2);
        run(0, 21, 1'b0);

        // reset in the MIX_S of iteration 40, then restart on the partial arrays
        init_mem(1'b0);
        @(negedge clk2);
        push_model(0);
        ia.start = 1'b1;
        bc = 0;
        for (int cyc = 0; cyc < 400 && bc < 81; cyc++) begin
            @(negedge clk2);
            ia.start = 1'b0;
            if (ia.busy) bc++;
        end
        chk("pre_rst_s_we", 64'(ia.S_we), 64'd1);
        chk("pre_rst_s_addr", 64'(ia.S_address), 64'd14);
        rst = 1'b1;
        #1;
        chk("mid_rst_s_we", 64'(ia.S_we), 64'd0);
        chk("mid_rst_l_we", 64'(ia.L_we), 64'd0);
        chk("mid_rst_busy", 64'(ia.busy), 64'd0);
        chk("mid_rst_done", 64'(ia.done), 64'd0);
        chk("mid_rst_s_addr", 64'(ia.S_address), 64'd0);
        chk("mid_rst_l_addr", 64'(ia.L_address), 64'd0);
        q_a.delete();
        @(negedge clk2);
        rst = 1'b0;
        @(negedge clk2);
        run(0, -1, 1'b0);

        // small table: t=5, c=3
        init_mem(1'b0);
        @(negedge clk2);
        run(1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
